mem_dump_reader: RTL and testbench

Sequential read-back engine for the single-clock block-RAM `memory` instance. It is the reader counterpart to the RAM write port and its `$readmemh`/`$readmemb` initialisation. On a start pulse it walks an address window of the RAM through the synchronous read port (`raddr`/`dout`). It then streams every word out on a valid/ready interface so post-reinit contents can be dumped and compared against the init file. It sits beside `memory` in `top`, owning `raddr` while busy.

---
 rtl/mem_dump_pkg.sv | 13 +
 rtl/mem_dump_fifo.sv | 61 ++++++
 rtl/mem_dump_reader.sv | 156 +++++++++++++++
 tb/tb_mem_dump_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump reader.
package mem_dump_pkg;

  localparam int unsigned AddrWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StCsum
  } mem_dump_state_e;

endpackage

// File: rtl/mem_dump_fifo.sv
// Synchronous output FIFO with asynchronous active-high reset; occupancy is exported so the
// reader can account for buffered words when deciding whether to issue another read.
module mem_dump_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_dump_reader.sv
// Walks an address window of the block RAM and streams each word on a valid/ready port.
// Define MEM_DUMP_CSUM_EN to append an XOR checksum beat after the data beats.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int unsigned WID_MEM    = 1,
  parameter int unsigned DEPTH_MEM  = 32768,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic [AddrWidth-1:0] mem_raddr,
  input  logic [WID_MEM-1:0]   mem_dout,
  output logic [WID_MEM-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int unsigned MemAw = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  mem_dump_state_e      state_q;
  logic [MemAw-1:0]     addr_q;
  logic [MemAw-1:0]     raddr_q;
  logic [AddrWidth-1:0] rem_q;
  logic                 inflight_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef MEM_DUMP_CSUM_EN
  logic [WID_MEM-1:0]   csum_q;
`else
  logic [AddrWidth-1:0] out_rem_q;
`endif

  logic                 issue;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 drain_done;
  logic [WID_MEM-1:0]   fifo_data;
  logic [CntW-1:0]      fifo_count;

  mem_dump_fifo #(
    .Width (WID_MEM),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (inflight_q),
    .data_i  (mem_dout),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // The in-flight read always has a reserved FIFO slot, so the FIFO can never overflow.
  assign issue      = (state_q == StRun) &&
                      ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
  assign fifo_pop   = !fifo_empty && m_ready;
  assign drain_done = !inflight_q &&
                      ((fifo_count == '0) || ((fifo_count == CntW'(1)) && fifo_pop));

`ifdef MEM_DUMP_CSUM_EN
  assign m_valid = (state_q == StCsum) || !fifo_empty;
  assign m_data  = (state_q == StCsum) ? csum_q : fifo_data;
  assign m_last  = (state_q == StCsum);
`else
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_data;
  assign m_last  = !fifo_empty && (out_rem_q == 32'd1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      raddr_q    <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_DUMP_CSUM_EN
      csum_q     <= '0;
`else
      out_rem_q  <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        raddr_q <= addr_q;
        addr_q  <= addr_q + MemAw'(1);
        rem_q   <= rem_q - 32'd1;
      end
      if (fifo_pop) begin
`ifdef MEM_DUMP_CSUM_EN
        csum_q    <= csum_q ^ fifo_data;
`else
        out_rem_q <= out_rem_q - 32'd1;
`endif
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= MemAw'(base);
            rem_q   <= len;
            busy_q  <= 1'b1;
            state_q <= (len == '0) ? StDrain : StRun;
`ifdef MEM_DUMP_CSUM_EN
            csum_q    <= '0;
`else
            out_rem_q <= len;
`endif
          end
        end
        StRun: begin
          if (issue && (rem_q == 32'd1)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_done) begin
`ifdef MEM_DUMP_CSUM_EN
            state_q <= StCsum;
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef MEM_DUMP_CSUM_EN
        StCsum: begin
          if (m_ready) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_raddr = AddrWidth'(raddr_q);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: expected beats are queued at start and checked as the
// stream hands them over; also covers wrap, stalls, zero length, mid-dump reset and the checksum.
module tb_mem_dump_reader;

  localparam int unsigned Depth = 32768;
  localparam int unsigned FifoD = 4;

  typedef struct {
    logic [0:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] len = '0;
  logic        busy, done;
  logic [31:0] mem_raddr;
  logic [0:0]  mem_dout;
  logic [0:0]  m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;

  logic [0:0]  ram [Depth];
  beat_t       exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rdy_mode = 0;
  int          beats = 0;
  int          dones = 0;
  logic        hold_v = 1'b0;
  logic [0:0]  hold_d = '0;
  logic        hold_l = 1'b0;

  mem_dump_reader #(
    .WID_MEM    (1),
    .DEPTH_MEM  (Depth),
    .FIFO_DEPTH (FifoD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // RAM read data corresponds to the registered read address during the following cycle.
  assign mem_dout = ram[mem_raddr[14:0]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (rdy_mode)
      1:       m_ready = ((cyc - start_cyc) % 4) == 0;
      2:       m_ready = (cyc - start_cyc) >= 20;
      default: m_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (done) dones++;
      if (hold_v) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_d));
        check("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_valid), 32'd0);
        end else if (m_ready) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e.data));
          check("beat_last", 32'(m_last), 32'(e.last));
          beats++;
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic push_expect(input logic [31:0] b, input logic [31:0] l);
    logic [0:0] cs;
    beat_t      e;
    cs = '0;
    for (int i = 0; i < int'(l); i++) begin
      e.data = ram[(b + 32'(i)) % Depth];
      e.last = (i == int'(l) - 1);
`ifdef MEM_DUMP_CSUM_EN
      e.last = 1'b0;
`endif
      cs = cs ^ e.data;
      exp_q.push_back(e);
    end
`ifdef MEM_DUMP_CSUM_EN
    e.data = cs;
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = b;
    len = l;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input logic [31:0] b, input logic [31:0] l, input int mode,
                          input bit chk_timing, input bit chk_addr);
    int  exp_done;
    bit  got_done;
`ifdef MEM_DUMP_CSUM_EN
    exp_done = (l == 0) ? 3 : int'(l) + 4;
`else
    exp_done = (l == 0) ? 2 : int'(l) + 3;
`endif
    got_done = 1'b0;
    rdy_mode = mode;
    push_expect(b, l);
    pulse_start(b, l);
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_run", 32'(busy), 32'd1);
      if (chk_timing && l > 0 && n == 2) check("valid_n2", 32'(m_valid), 32'd0);
      if (chk_timing && l > 0 && n == 3) check("first_valid", 32'(m_valid), 32'd1);
      if (chk_addr && n == 2) check("raddr_hi", 32'(mem_raddr[31:15]), 32'd0);
      if (chk_addr && n >= 2 && n < 2 + int'(l))
        check("raddr_seq", mem_raddr, (b + 32'(n - 2)) % Depth);
      if (mode == 2 && n == 19) begin
        check("stall_raddr", mem_raddr, (b + FifoD - 1) % Depth);
        check("stall_valid", 32'(m_valid), 32'd1);
      end
      if (done) begin
        if (chk_timing) check("done_cycle", 32'(n), 32'(exp_done));
        check("busy_at_done", 32'(busy), 32'd0);
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int b0;
    bit hit;
    for (int i = 0; i < int'(Depth); i++) ram[i] = 1'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raddr", mem_raddr, 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Alternating pattern, full throughput.
    run_dump(32'd0, 32'd8, 0, 1'b1, 1'b1);

    // Address wrap at the top of the RAM.
    ram[32766] = 1'b1;
    ram[32767] = 1'b0;
    ram[0]     = 1'b1;
    ram[1]     = 1'b1;
    run_dump(32'd32766, 32'd4, 0, 1'b1, 1'b1);
    ram[32766] = 1'b0;
    ram[32767] = 1'b1;
    ram[0]     = 1'b0;
    ram[1]     = 1'b1;

    // Ready high one cycle in four.
    run_dump(32'd3, 32'd16, 1, 1'b0, 1'b0);

    // Zero length.
    run_dump(32'd5, 32'd0, 0, 1'b1, 1'b0);

    // Long stall: issue must stop with FIFO_DEPTH words outstanding.
    run_dump(32'd40, 32'd9, 2, 1'b0, 1'b0);

    // Start while busy is ignored.
    rdy_mode = 1;
    push_expect(32'd10, 32'd6);
    pulse_start(32'd10, 32'd6);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = 32'd11;
    len = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      hit = done;
    end
    check("busy_start_done", 32'(hit), 32'd1);
    check("busy_start_sb", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a dump.
    rdy_mode = 0;
    push_expect(32'd200, 32'd10);
    b0 = beats;
    pulse_start(32'd200, 32'd10);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(posedge clk);
      hit = (beats >= b0 + 5);
    end
    check("mid_reset_reach", 32'(hit), 32'd1);
    d0 = dones;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_valid", 32'(m_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_no_done", 32'(dones), 32'(d0));
    b0 = beats;
    run_dump(32'd7, 32'd3, 0, 1'b1, 1'b0);
`ifdef MEM_DUMP_CSUM_EN
    check("post_reset_beats", 32'(beats - b0), 32'd4);
`else
    check("post_reset_beats", 32'(beats - b0), 32'd3);
`endif

    // Words 1,1,0,1 (checksum 1 when enabled).
    ram[100] = 1'b1;
    ram[101] = 1'b1;
    ram[102] = 1'b0;
    ram[103] = 1'b1;
    run_dump(32'd100, 32'd4, 0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
